// File: rtl/modexp_ladder_seq_pkg.sv
// Shared types and timing helpers for the Montgomery-ladder modular exponentiator.
package modexp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDUCE = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // Start-to-done latency of a normal (n >= 2) operation, in clock cycles.
  function automatic int lat(input int w, input int ew);
    return (ew + 1) * (w + 1) + 1;
  endfunction

endpackage

// File: rtl/modexp_ladder_seq_if.sv
// Start/done request bus of the exponentiator; master issues operands, slave returns results.
interface modexp_ladder_seq_if #(
  parameter int W  = 16,
  parameter int EW = 16
);
  logic          start;
  logic [W-1:0]  x;
  logic [EW-1:0] e;
  logic [W-1:0]  n;
  logic          busy;
  logic          done;
  logic [W-1:0]  y;
  logic          err;

  modport master (output start, x, e, n, input busy, done, y, err);
  modport slave  (input start, x, e, n, output busy, done, y, err);
endinterface

// File: rtl/modexp_ladder_seq_mul.sv
// Bit-serial interleaved modular multiplier: p = a*b mod n, requires a < n.
module mod_mul_serial #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         rdy,
  output logic [W-1:0] p
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_q, a_d, b_q, b_d, n_q, n_d;
  logic [W:0]    acc_q, acc_d, acc_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;

  // One MSB-first iteration; acc stays below n so W+1 bits never overflow.
  always_comb begin
    acc_nxt = acc_q << 1;
    if (acc_nxt >= {1'b0, n_q}) acc_nxt = acc_nxt - {1'b0, n_q};
    if (b_q[W-1])               acc_nxt = acc_nxt + {1'b0, a_q};
    if (acc_nxt >= {1'b0, n_q}) acc_nxt = acc_nxt - {1'b0, n_q};
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    n_d   = n_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (go) begin
      a_d   = a;
      b_d   = b;
      n_d   = n;
      acc_d = '0;
      cnt_d = CW'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = acc_nxt;
      b_d   = b_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      n_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      n_q   <= n_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // Result is presented during the final iteration so the caller can chain without a bubble.
  assign rdy = run_q && (cnt_q == CW'(1));
  assign p   = acc_nxt[W-1:0];

endmodule

// File: rtl/modexp_ladder_seq.sv
// Montgomery-ladder Y = X^E mod N with constant per-bit work; latency depends only on W and EW.
// state  | meaning
// IDLE   | waiting for start; y/err hold last result
// REDUCE | multiplier 0 computes x mod n as 1*x mod n
// STEP   | both multipliers process exponent bit e[idx]
// FINISH | publish R0 (or fast-path result); done follows
module modexp_ladder_seq
  import modexp_pkg::*;
#(
  parameter int W  = 16,
  parameter int EW = 16
) (
  input logic                clk,
  input logic                rst_n,
  modexp_ladder_seq_if.slave bus
);
  localparam int IW = (EW > 1) ? $clog2(EW) : 1;

  localparam logic [1:0] IDLE   = ST_IDLE;
  localparam logic [1:0] REDUCE = ST_REDUCE;
  localparam logic [1:0] STEP   = ST_STEP;
  localparam logic [1:0] FINISH = ST_FINISH;

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] e_q, e_d;
  logic [W-1:0]  n_q, n_d, r0_q, r0_d, r1_q, r1_d, y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          go_q, go_d, done_q, done_d, err_q, err_d, fast_q, fast_d;
  logic [31:0]   cyc_q, cyc_d;

  logic          busy, accept, fast, bit_e;
  logic          go0, rdy0, rdy1;
  logic [W-1:0]  a0, b0, n0, a1, p0, p1;

  assign busy   = (state_q != IDLE) || done_q;
  assign accept = bus.start && !busy;
  assign fast   = (bus.n < W'(2));
  assign bit_e  = e_q[idx_q];

  // REDUCE is launched straight from the start cycle using the raw inputs.
  always_comb begin
    go0 = go_q;
    a0  = r0_q;
    b0  = r1_q;
    n0  = n_q;
    if (accept && !fast) begin
      go0 = 1'b1;
      a0  = W'(1);
      b0  = bus.x;
      n0  = bus.n;
    end
  end

  assign a1 = bit_e ? r1_q : r0_q;

  mod_mul_serial #(.W(W)) u_mul0 (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go0),
    .a     (a0),
    .b     (b0),
    .n     (n0),
    .rdy   (rdy0),
    .p     (p0)
  );

  mod_mul_serial #(.W(W)) u_mul1 (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go_q),
    .a     (a1),
    .b     (a1),
    .n     (n_q),
    .rdy   (rdy1),
    .p     (p1)
  );

  always_comb begin
    state_d = state_q;
    e_d     = e_q;
    n_d     = n_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    y_d     = y_q;
    err_d   = err_q;
    idx_d   = idx_q;
    fast_d  = fast_q;
    go_d    = 1'b0;
    done_d  = 1'b0;
    cyc_d   = accept ? 32'd1 : cyc_q + 32'd1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          e_d     = bus.e;
          n_d     = bus.n;
          r0_d    = '0;
          r1_d    = '0;
          idx_d   = '0;
          y_d     = '0;
          err_d   = 1'b0;
          fast_d  = fast;
          state_d = fast ? FINISH : REDUCE;
        end
      end
      REDUCE: begin
        if (rdy0) begin
          r0_d    = W'(1);
          r1_d    = p0;
          idx_d   = IW'(EW - 1);
          go_d    = 1'b1;
          state_d = STEP;
        end
      end
      STEP: begin
        if (rdy0 && rdy1) begin
          if (bit_e) begin
            r0_d = p0;
            r1_d = p1;
          end else begin
            r1_d = p0;
            r0_d = p1;
          end
          if (idx_q == '0) begin
            state_d = FINISH;
          end else begin
            idx_d = idx_q - 1'b1;
            go_d  = 1'b1;
          end
        end
      end
      FINISH: begin
        y_d     = r0_q;
        err_d   = (n_q == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      e_q     <= '0;
      n_q     <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      fast_q  <= 1'b0;
      go_q    <= 1'b0;
      done_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      e_q     <= e_d;
      n_q     <= n_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      y_q     <= y_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      fast_q  <= fast_d;
      go_q    <= go_d;
      done_q  <= done_d;
      cyc_q   <= cyc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && done_q)
      assert (cyc_q == (fast_q ? 32'd2 : 32'(lat(W, EW))));
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_modexp_ladder_seq.sv
// Scoreboard bench for modexp_ladder_seq: driver queues expected results, monitor checks each done.
module tb_modexp_ladder_seq;
  import modexp_pkg::*;

  localparam int W  = 8;
  localparam int EW = 8;

  typedef struct {
    logic [W-1:0] y;
    logic         err;
    int           t0;
    int           lat;
    int           id;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   op_id = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  modexp_ladder_seq_if #(.W(W), .EW(EW)) bus ();

  modexp_ladder_seq #(.W(W), .EW(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Left-to-right square-and-multiply; returns {err, y}.
  function automatic logic [W:0] ref_model(input int xv, input int ev, input int nv);
    int r, b;
    if (nv == 0) return {1'b1, W'(0)};
    r = 1 % nv;
    b = xv % nv;
    for (int i = EW - 1; i >= 0; i--) begin
      r = (r * r) % nv;
      if (((ev >> i) & 1) != 0) r = (r * b) % nv;
    end
    return {1'b0, W'(r)};
  endfunction

  task automatic check(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, expv);
    end
  endtask

  // Drives one start pulse in the next cycle and queues the expected response.
  task automatic issue(input int xv, input int ev, input int nv, input int yexp, input int eexp);
    exp_t s;
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = W'(xv);
    bus.e     = EW'(ev);
    bus.n     = W'(nv);
    op_id++;
    s.y   = W'(yexp);
    s.err = eexp[0];
    s.t0  = cyc;
    s.lat = (nv < 2) ? 2 : lat(W, EW);
    s.id  = op_id;
    sb_q.push_back(s);
    @(negedge clk);
    bus.start = 1'b0;
    bus.x     = W'($urandom_range(0, 255));
    bus.e     = EW'($urandom_range(0, 255));
    bus.n     = W'($urandom_range(0, 255));
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((bus.busy || sb_q.size() != 0) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: busy=%0d pending=%0d, expected idle", bus.busy, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic pulse_reset_and_check(input string name);
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_done"}, int'(bus.done), 0);
    check({name, "_y"}, int'(bus.y), 0);
    check({name, "_err"}, int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every done must match the oldest queued expectation.
  initial begin
    exp_t s;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got done with y=%0d, expected no done", bus.y);
        end else begin
          s = sb_q.pop_front();
          if (bus.y !== s.y || bus.err !== s.err || (cyc - s.t0) != s.lat) begin
            miscompares++;
            $display("FAIL op%0d: got y=%0d err=%0d lat=%0d, expected y=%0d err=%0d lat=%0d",
                     s.id, bus.y, bus.err, cyc - s.t0, s.y, s.err, s.lat);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, xv, ev, nv;
    logic [W:0] r;
    bus.start = 1'b0;
    bus.x = '0;
    bus.e = '0;
    bus.n = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_y", int'(bus.y), 0);
    check("reset_err", int'(bus.err), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(3, 5, 7, 5, 0);        wait_idle();
    issue(10, 3, 7, 6, 0);       wait_idle();
    issue(2, 10, 200, 24, 0);    wait_idle();
    repeat (3) @(negedge clk);
    check("hold_y", int'(bus.y), 24);
    pulse_reset_and_check("rst_after_result");

    issue(5, 0, 7, 1, 0);        wait_idle();
    issue(0, 255, 9, 0, 0);      wait_idle();
    issue(77, 200, 0, 0, 1);     wait_idle();
    check("hold_err", int'(bus.err), 1);
    pulse_reset_and_check("rst_after_err");
    issue(200, 13, 1, 0, 0);     wait_idle();

    // Back-to-back: second start issued in the cycle right after done.
    issue(123, 45, 251, int'(ref_model(123, 45, 251)), 0);
    k = 0;
    while (!bus.done && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) check("b2b_done_seen", 0, 1);
    issue(9, 200, 100, int'(ref_model(9, 200, 100)), 0);
    wait_idle();

    // Starts and operand changes while busy are ignored.
    issue(7, 11, 13, int'(ref_model(7, 11, 13)), 0);
    repeat (6) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.x = W'($urandom_range(0, 255));
      bus.e = EW'($urandom_range(0, 255));
      bus.n = W'($urandom_range(0, 255));
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
    repeat (100) @(negedge clk);

    // Reset at cycle 40 abandons the operation; no done may follow.
    issue(45, 170, 211, 0, 0);
    repeat (39) @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("midop_rst_busy", int'(bus.busy), 0);
    check("midop_rst_y", int'(bus.y), 0);
    check("midop_rst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    issue(45, 170, 211, int'(ref_model(45, 170, 211)), 0);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      xv = $urandom_range(0, 255);
      ev = $urandom_range(0, 255);
      nv = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 255);
      r  = ref_model(xv, ev, nv);
      issue(xv, ev, nv, int'(r[W-1:0]), int'(r[W]));
      wait_idle();
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
